// File: rtl/scan_mux.sv
// Registered N-to-1 channel multiplexer with direct-select and auto-scan modes.
// Out-of-range selects produce zero data; the scan index always stays below N.
module scan_mux #(
  parameter int N  = 16,
  parameter int W  = 1,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  A,
  input  logic [SW-1:0]   S,
  input  logic            mode,
  input  logic            en,
  input  logic            load,
  output logic [W-1:0]    y,
  output logic [SW-1:0]   ch,
  output logic            valid,
  output logic            wrap
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic [SW:0]   N_EXT = (SW+1)'(N);
  localparam logic [SW-1:0] LAST  = SW'(N - 1);

  state_t        state, state_d;
  logic [SW-1:0] idx, idx_d;
  logic [W-1:0]  y_d;
  logic [SW-1:0] ch_d;
  logic          valid_d, wrap_d;

  logic          s_oob;
  logic [W-1:0]  a_s, a_idx;

  // Constant-false when N is a power of two; S can then never exceed N-1.
  assign s_oob = ({1'b0, S} >= N_EXT);

  // Loop muxes instead of variable part-selects so an out-of-range S yields zero.
  always_comb begin
    a_s   = '0;
    a_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (S == SW'(k))   a_s   = A[k*W +: W];
      if (idx == SW'(k)) a_idx = A[k*W +: W];
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    y_d     = y;
    ch_d    = ch;
    valid_d = 1'b0;
    wrap_d  = 1'b0;

    if (load) idx_d = s_oob ? '0 : S;

    if (en) begin
      state_d = mode ? SCAN : DIRECT;
      if (!mode || load) begin
        ch_d    = S;
        y_d     = s_oob ? '0 : a_s;
        valid_d = !s_oob;
        if (mode && !s_oob) begin
          wrap_d = (S == LAST);
          idx_d  = (S == LAST) ? '0 : S + 1'b1;
        end
      end else begin
        ch_d    = idx;
        y_d     = a_idx;
        valid_d = 1'b1;
        wrap_d  = (idx == LAST);
        idx_d   = (idx == LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      y     <= '0;
      ch    <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      y     <= y_d;
      ch    <= ch_d;
      valid <= valid_d;
      wrap  <= wrap_d;
    end
  end

endmodule
